// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side streamer.
// Provides the streamer FSM state encoding and the default data width.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int BURST_LEN_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_streamer_skid_buf2.sv
// skid_buf2: 2-entry in-order buffer that absorbs the FIFO read latency.
// Ports: clk, rst (sync, active-high), push/din (write), pop (read),
//        count (entries held, 0..2), head (oldest entry).
module skid_buf2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    // A push into a full buffer is accepted only when a pop frees a slot.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: turns a sync-FIFO read port into a framed valid/ready stream.
// Ports: clk, rst (sync, active-high); FIFO side fifo_empty, fifo_data_out,
//        fifo_underflow, fifo_rd_en; stream side m_valid, m_ready, m_data, m_last;
//        control flush/flush_done; sticky err_underflow.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  err_underflow
);

    localparam int            CW       = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    rd_state_e     state;
    rd_state_e     state_nxt;
    logic          inflight;
    logic [1:0]    buf_cnt;
    logic          pop;
    logic          pipe_empty;
    logic          credit_ok;
    logic [CW-1:0] beat_cnt;

    assign pop        = m_valid && m_ready;
    assign pipe_empty = (buf_cnt == 2'd0) && !inflight;

    // Issue a read only if its data is sure to find a free skid slot:
    // occupancy after this cycle's pop, plus the new read, must stay <= 2.
    assign credit_ok = ({1'b0, buf_cnt} + {2'b00, inflight})
                       < (3'd2 + {2'b00, pop});

    skid_buf2 #(
        .W(FIFO_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (fifo_data_out),
        .pop   (pop),
        .count (buf_cnt),
        .head  (m_data)
    );

    assign m_valid = (buf_cnt != 2'd0);

    // The final buffered beat of a drain closes the burst early.
    assign m_last = m_valid &&
                    ((beat_cnt == LAST_IDX) ||
                     (state == ST_DRAIN && buf_cnt == 2'd1 && !inflight));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush)           state_nxt = ST_DRAIN;
                else if (fifo_rd_en) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (flush)                         state_nxt = ST_DRAIN;
                else if (pipe_empty && fifo_empty) state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (pipe_empty) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        flush_done = 1'b0;
        case (state)
            ST_IDLE, ST_ACTIVE: fifo_rd_en = !rst && !fifo_empty && credit_ok;
            ST_DRAIN:           flush_done = pipe_empty;
            default:            ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight      <= 1'b0;
            beat_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (fifo_underflow) err_underflow <= 1'b1;
            if (flush_done)     beat_cnt <= '0;
            else if (pop)       beat_cnt <= m_last ? '0 : beat_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural sync-FIFO model.
// Scenarios: reset, streaming, back-pressure, flush, empty toggling, reset mid-burst.
module tb_fifo_rd_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_underflow = 1'b0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_last;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        err_underflow;

    int tests = 0;
    int failed = 0;

    logic [15:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        toggle_mode = 1'b0;

    logic [15:0] rx_d [64];
    logic        rx_l [64];
    int          rx_c [64];
    int          rx_n = 0;
    int          cyc = 0;

    fifo_rd_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .flush          (flush),
        .flush_done     (flush_done),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, registered empty flag.
    always @(posedge clk) begin
        int lvl;
        lvl = wr_ptr - rd_ptr;
        if (fifo_rd_en && lvl > 0) begin
            fifo_data_out <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
            lvl = lvl - 1;
        end
        if (toggle_mode) fifo_empty <= (lvl == 0) ? 1'b1 : ~fifo_empty;
        else             fifo_empty <= (lvl == 0);
    end

    // Record every accepted beat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_valid === 1'b1 && m_ready && !rst && rx_n < 64) begin
            rx_d[rx_n] <= m_data;
            rx_l[rx_n] <= m_last;
            rx_c[rx_n] <= cyc;
            rx_n <= rx_n + 1;
        end
    end

    task automatic load(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + 16'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic wait_rx(input int target, input int budget);
        int k;
        k = 0;
        while (rx_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        load(16'h0055, 1);
        repeat (2) begin
            @(negedge clk);
            #1;
            tests++;
            if ({fifo_rd_en, m_valid, m_last, flush_done, err_underflow} !== 5'b0) begin
                failed++;
                $display("FAIL reset_outputs: got %b, want 00000",
                         {fifo_rd_en, m_valid, m_last, flush_done, err_underflow});
            end
        end
        rst = 1'b0;
        m_ready = 1'b1;
        wait_rx(1, 12);
        tests++;
        if (rx_n !== 1 || rx_d[0] !== 16'h0055 || rx_l[0] !== 1'b0) begin
            failed++;
            $display("FAIL reset_first_beat: got n=%0d d=%h l=%b, want n=1 d=0055 l=0",
                     rx_n, rx_d[0], rx_l[0]);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests++;
        if ({flush_done, m_valid} !== 2'b10) begin
            failed++;
            $display("FAIL idle_flush_done: got %b, want 10", {flush_done, m_valid});
        end
        @(negedge clk);
        #1;
        tests++;
        if (flush_done !== 1'b0) begin
            failed++;
            $display("FAIL idle_flush_pulse: got %b, want 0", flush_done);
        end
    endtask

    task automatic test_stream();
        int base;
        logic exp_l;
        base = rx_n;
        load(16'h0001, 8);
        wait_rx(base + 8, 40);
        tests++;
        if (rx_n - base !== 8) begin
            failed++;
            $display("FAIL stream_count: got %0d, want 8", rx_n - base);
        end
        for (int i = 0; i < 8; i++) begin
            exp_l = (i == 3 || i == 7);
            tests++;
            if (rx_d[base+i] !== 16'(i + 1) || rx_l[base+i] !== exp_l) begin
                failed++;
                $display("FAIL stream_beat%0d: got d=%h l=%b, want d=%h l=%b",
                         i, rx_d[base+i], rx_l[base+i], 16'(i + 1), exp_l);
            end
        end
        tests++;
        if (rx_c[base+7] - rx_c[base] !== 7) begin
            failed++;
            $display("FAIL stream_back_to_back: got span %0d, want 7",
                     rx_c[base+7] - rx_c[base]);
        end
    endtask

    task automatic test_back_pressure();
        int base;
        int rb;
        logic exp_l;
        base = rx_n;
        rb = rd_ptr;
        load(16'h0011, 8);
        m_ready = 1'b1;
        wait_rx(base + 1, 20);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if ({m_valid, m_last, fifo_rd_en} !== 3'b100 || m_data !== 16'h0012) begin
                failed++;
                $display("FAIL bp_hold%0d: got v=%b l=%b rd=%b d=%h, want v=1 l=0 rd=0 d=0012",
                         i, m_valid, m_last, fifo_rd_en, m_data);
            end
            @(negedge clk);
        end
        tests++;
        if (rd_ptr - rb !== 3) begin
            failed++;
            $display("FAIL bp_reads_stalled: got %0d, want 3", rd_ptr - rb);
        end
        m_ready = 1'b1;
        wait_rx(base + 8, 40);
        repeat (3) @(negedge clk);
        tests++;
        if (rx_n - base !== 8 || rd_ptr - rb !== 8) begin
            failed++;
            $display("FAIL bp_count: got beats=%0d reads=%0d, want 8 8",
                     rx_n - base, rd_ptr - rb);
        end
        for (int i = 0; i < 8; i++) begin
            exp_l = (i == 3 || i == 7);
            tests++;
            if (rx_d[base+i] !== 16'h0011 + 16'(i) || rx_l[base+i] !== exp_l) begin
                failed++;
                $display("FAIL bp_beat%0d: got d=%h l=%b, want d=%h l=%b",
                         i, rx_d[base+i], rx_l[base+i], 16'h0011 + 16'(i), exp_l);
            end
        end
    endtask

    task automatic test_flush();
        int base;
        int rb;
        int k;
        base = rx_n;
        rb = rd_ptr;
        load(16'h00A0, 6);
        m_ready = 1'b1;
        wait_rx(base + 2, 20);
        m_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_ready = 1'b1;
        #1;
        tests++;
        if ({m_valid, m_last, flush_done} !== 3'b100 || m_data !== 16'h00A2) begin
            failed++;
            $display("FAIL flush_head: got v=%b l=%b fd=%b d=%h, want v=1 l=0 fd=0 d=00a2",
                     m_valid, m_last, flush_done, m_data);
        end
        k = 0;
        while (flush_done !== 1'b1 && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        tests++;
        if (flush_done !== 1'b1 || k !== 2) begin
            failed++;
            $display("FAIL flush_done_latency: got fd=%b after %0d, want fd=1 after 2",
                     flush_done, k);
        end
        @(negedge clk);
        #1;
        tests++;
        if (flush_done !== 1'b0) begin
            failed++;
            $display("FAIL flush_done_pulse: got %b, want 0", flush_done);
        end
        tests++;
        if (rx_n - base !== 4 || rd_ptr - rb !== 4) begin
            failed++;
            $display("FAIL flush_counts: got beats=%0d reads=%0d, want 4 4",
                     rx_n - base, rd_ptr - rb);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rx_d[base+i] !== 16'h00A0 + 16'(i) || rx_l[base+i] !== (i == 3)) begin
                failed++;
                $display("FAIL flush_beat%0d: got d=%h l=%b, want d=%h l=%b",
                         i, rx_d[base+i], rx_l[base+i], 16'h00A0 + 16'(i), (i == 3));
            end
        end
        base = rx_n;
        m_ready = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        tests++;
        if (rd_ptr - rb !== 6 || {m_valid, m_last} !== 2'b10 || m_data !== 16'h00A4) begin
            failed++;
            $display("FAIL flush2_fill: got reads=%0d v=%b l=%b d=%h, want 6 1 0 00a4",
                     rd_ptr - rb, m_valid, m_last, m_data);
        end
        flush = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests++;
        if ({m_valid, m_last} !== 2'b11 || m_data !== 16'h00A5) begin
            failed++;
            $display("FAIL drain_last: got v=%b l=%b d=%h, want v=1 l=1 d=00a5",
                     m_valid, m_last, m_data);
        end
        @(negedge clk);
        #1;
        tests++;
        if (flush_done !== 1'b1 || rx_n - base !== 2 || rx_l[base] !== 1'b0 ||
            rx_l[base+1] !== 1'b1) begin
            failed++;
            $display("FAIL flush2_done: got fd=%b n=%0d l0=%b l1=%b, want 1 2 0 1",
                     flush_done, rx_n - base, rx_l[base], rx_l[base+1]);
        end
    endtask

    task automatic test_empty_boundary();
        int base;
        int rb;
        int viol;
        base = rx_n;
        rb = rd_ptr;
        viol = 0;
        toggle_mode = 1'b1;
        load(16'h0100, 11);
        m_ready = 1'b1;
        repeat (22) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en && fifo_empty) viol++;
        end
        tests++;
        if (viol !== 0 || rd_ptr - rb < 1) begin
            failed++;
            $display("FAIL rd_en_while_empty: got viol=%0d reads=%0d, want 0 and >0",
                     viol, rd_ptr - rb);
        end
        toggle_mode = 1'b0;
        wait_rx(base + 11, 60);
        tests++;
        if (rx_n - base !== 11) begin
            failed++;
            $display("FAIL toggle_count: got %0d, want 11", rx_n - base);
        end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (rx_d[base+i] !== 16'h0100 + 16'(i) || rx_l[base+i] !== ((i % 4) == 3)) begin
                failed++;
                $display("FAIL toggle_beat%0d: got d=%h l=%b, want d=%h l=%b",
                         i, rx_d[base+i], rx_l[base+i], 16'h0100 + 16'(i), ((i % 4) == 3));
            end
        end
        tests++;
        if (err_underflow !== 1'b0) begin
            failed++;
            $display("FAIL err_quiet: got %b, want 0", err_underflow);
        end
        @(negedge clk);
        fifo_underflow = 1'b1;
        @(negedge clk);
        fifo_underflow = 1'b0;
        #1;
        tests++;
        if (err_underflow !== 1'b1) begin
            failed++;
            $display("FAIL err_set: got %b, want 1", err_underflow);
        end
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (err_underflow !== 1'b1) begin
            failed++;
            $display("FAIL err_sticky: got %b, want 1", err_underflow);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int rb;
        @(negedge clk);
        m_ready = 1'b0;
        base = rx_n;
        rb = rd_ptr;
        load(16'h00B0, 4);
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b1 || m_data !== 16'h00B0 || rd_ptr - rb !== 2) begin
            failed++;
            $display("FAIL mid_fill: got v=%b d=%h reads=%0d, want 1 00b0 2",
                     m_valid, m_data, rd_ptr - rb);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if ({m_valid, fifo_rd_en, m_last, err_underflow} !== 4'b0) begin
            failed++;
            $display("FAIL mid_reset_outputs: got %b, want 0000",
                     {m_valid, fifo_rd_en, m_last, err_underflow});
        end
        rst = 1'b0;
        m_ready = 1'b1;
        wait_rx(base + 2, 20);
        repeat (2) @(negedge clk);
        tests++;
        if (rx_n - base !== 2 || rx_d[base] !== 16'h00B2 || rx_l[base] !== 1'b0) begin
            failed++;
            $display("FAIL post_reset_first: got n=%0d d=%h l=%b, want 2 00b2 0",
                     rx_n - base, rx_d[base], rx_l[base]);
        end
        tests++;
        if (rx_d[base+1] !== 16'h00B3 || rx_l[base+1] !== 1'b0 || rd_ptr - rb !== 4) begin
            failed++;
            $display("FAIL post_reset_second: got d=%h l=%b reads=%0d, want 00b3 0 4",
                     rx_d[base+1], rx_l[base+1], rd_ptr - rb);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_empty_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
